// File: rtl/cp0_unit.sv
// Coprocessor-0: SR/Cause/EPC registers, interrupt/exception request, mfc0/mtc0/eret.
// Optional macro CP0_PRID_EN exposes PRID_VALUE as read-only register 15.
module cp0_unit #(
  parameter logic [31:0] PRID_VALUE = 32'h2023_0001
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] Din,
  input  logic        WE,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic [31:0] Dout,
  output logic [31:0] EPCOut,
  output logic        Req
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic [31:0] sr_word;
  logic [31:0] cause_word;

  logic unused_din;
  assign unused_din = ^{Din[31:16], Din[9:2]};

  assign int_req = (|(HWInt & sr_im)) & sr_ie & ~sr_exl;
  assign exc_req = (ExcCodeIn != 5'd0) & ~sr_exl;
  assign Req     = int_req | exc_req;
  assign EPCOut  = epc;

  assign sr_word    = {16'b0, sr_im, 8'b0, sr_exl, sr_ie};
  assign cause_word = {cause_bd, 15'b0, cause_ip, 3'b0, cause_exc, 2'b0};

  // A request discards any concurrent mtc0; otherwise the write lands first and
  // eret's EXL clear overrides the EXL bit it carried.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= HWInt;
      if (Req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= BDIn;
        cause_exc <= int_req ? 5'd0 : ExcCodeIn;
        epc       <= BDIn ? VPC - 32'd4 : VPC;
      end else begin
        if (WE && A2 == 5'd12) begin
          sr_im  <= Din[15:10];
          sr_exl <= Din[1];
          sr_ie  <= Din[0];
        end
        if (WE && A2 == 5'd14) begin
          epc <= Din;
        end
        if (EXLClr) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

`ifdef CP0_PRID_EN
  always_comb begin
    Dout = '0;
    case (A1)
      5'd12:   Dout = sr_word;
      5'd13:   Dout = cause_word;
      5'd14:   Dout = epc;
      5'd15:   Dout = PRID_VALUE;
      default: Dout = '0;
    endcase
  end
`else
  localparam logic [31:0] unused_prid = PRID_VALUE;

  always_comb begin
    Dout = '0;
    case (A1)
      5'd12:   Dout = sr_word;
      5'd13:   Dout = cause_word;
      5'd14:   Dout = epc;
      default: Dout = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_cp0_unit.sv
// Directed self-checking bench for cp0_unit: reset, interrupt/exception entry,
// eret, register access rules and the optional PRID register.
module tb_cp0_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] Din;
  logic        WE;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic [31:0] Dout;
  logic [31:0] EPCOut;
  logic        Req;

  int total = 0;
  int bad = 0;

  cp0_unit #(.PRID_VALUE(32'h2023_0001)) dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .Din(Din), .WE(WE),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .Dout(Dout), .EPCOut(EPCOut), .Req(Req)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    WE = 1'b0; A2 = 5'd0; Din = '0; VPC = '0; BDIn = 1'b0;
    ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; A1 = 5'd0; idle_inputs();
    tick(); tick();
    reset = 1'b0;
    for (int i = 12; i <= 14; i++) begin
      A1 = 5'(i); #1;
      total++;
      if (Dout !== 32'h0) begin
        bad++; $display("FAIL reset_dout_%0d got=%h exp=%h", i, Dout, 32'h0);
      end
    end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL reset_req got=%b exp=0", Req); end
    total++;
    if (EPCOut !== 32'h0) begin bad++; $display("FAIL reset_epc got=%h exp=0", EPCOut); end
  endtask

  task automatic test_interrupt();
    WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0401;
    tick();
    WE = 1'b0; HWInt = 6'b000001; VPC = 32'h3010; BDIn = 1'b0; #1;
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL int_req got=%b exp=1", Req); end
    tick();
    HWInt = '0;
    total++;
    if (EPCOut !== 32'h3010) begin bad++; $display("FAIL int_epc got=%h exp=%h", EPCOut, 32'h3010); end
    A1 = 5'd13; #1;
    total++;
    if (Dout !== 32'h0000_0400) begin bad++; $display("FAIL int_cause got=%h exp=%h", Dout, 32'h0000_0400); end
    A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0000_0403) begin bad++; $display("FAIL int_sr got=%h exp=%h", Dout, 32'h0000_0403); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL int_req_after got=%b exp=0", Req); end
  endtask

  task automatic test_cause_readonly();
    HWInt = 6'b000100; WE = 1'b1; A2 = 5'd13; Din = 32'hFFFF_FFFF;
    tick();
    WE = 1'b0; HWInt = '0; A1 = 5'd13; #1;
    total++;
    if (Dout !== 32'h0000_1000) begin bad++; $display("FAIL cause_wr got=%h exp=%h", Dout, 32'h0000_1000); end
    A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0000_0403) begin bad++; $display("FAIL cause_wr_sr got=%h exp=%h", Dout, 32'h0000_0403); end
    total++;
    if (EPCOut !== 32'h3010) begin bad++; $display("FAIL cause_wr_epc got=%h exp=%h", EPCOut, 32'h3010); end
  endtask

  task automatic test_exception_vs_write();
    EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0;
    ExcCodeIn = 5'd10; BDIn = 1'b1; VPC = 32'h3024;
    WE = 1'b1; A2 = 5'd14; Din = 32'h1234; #1;
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL exc_req got=%b exp=1", Req); end
    tick();
    idle_inputs();
    total++;
    if (EPCOut !== 32'h3020) begin bad++; $display("FAIL exc_epc got=%h exp=%h", EPCOut, 32'h3020); end
    A1 = 5'd13; #1;
    total++;
    if (Dout !== 32'h8000_0028) begin bad++; $display("FAIL exc_cause got=%h exp=%h", Dout, 32'h8000_0028); end
    A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0000_0403) begin bad++; $display("FAIL exc_sr got=%h exp=%h", Dout, 32'h0000_0403); end
  endtask

  task automatic test_eret();
    WE = 1'b1; A2 = 5'd12; Din = 32'h0000_FC03;
    tick();
    WE = 1'b0; HWInt = 6'b111111; ExcCodeIn = 5'd4; #1;
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL eret_masked_req got=%b exp=0", Req); end
    EXLClr = 1'b1;
    tick();
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL eret_req got=%b exp=1", Req); end
    A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0000_FC01) begin bad++; $display("FAIL eret_sr got=%h exp=%h", Dout, 32'h0000_FC01); end
    // EXLClr held into the request cycle; EPC wraps below zero
    VPC = 32'h0; BDIn = 1'b1;
    tick();
    idle_inputs();
    #1;
    total++;
    if (Dout !== 32'h0000_FC03) begin bad++; $display("FAIL req_eret_sr got=%h exp=%h", Dout, 32'h0000_FC03); end
    total++;
    if (EPCOut !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_epc got=%h exp=%h", EPCOut, 32'hFFFF_FFFC); end
    A1 = 5'd13; #1;
    total++;
    if (Dout !== 32'h8000_FC00) begin bad++; $display("FAIL int_prio_cause got=%h exp=%h", Dout, 32'h8000_FC00); end
  endtask

  task automatic test_write_rules();
    WE = 1'b1; A2 = 5'd12; Din = 32'h0000_0403; EXLClr = 1'b1;
    tick();
    EXLClr = 1'b0; A2 = 5'd5; Din = 32'hFFFF_FFFF; A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0000_0401) begin bad++; $display("FAIL eret_wr_sr got=%h exp=%h", Dout, 32'h0000_0401); end
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL eret_wr_req got=%b exp=0", Req); end
    tick();
    A2 = 5'd14; Din = 32'hABCD_0000; #1;
    total++;
    if (Dout !== 32'h0000_0401) begin bad++; $display("FAIL other_reg_sr got=%h exp=%h", Dout, 32'h0000_0401); end
    A1 = 5'd3; #1;
    total++;
    if (Dout !== 32'h0) begin bad++; $display("FAIL unmapped_read got=%h exp=0", Dout); end
    A1 = 5'd14; #1;
    total++;
    if (Dout !== 32'hFFFF_FFFC) begin bad++; $display("FAIL no_bypass got=%h exp=%h", Dout, 32'hFFFF_FFFC); end
    tick();
    WE = 1'b0;
    total++;
    if (Dout !== 32'hABCD_0000) begin bad++; $display("FAIL epc_write got=%h exp=%h", Dout, 32'hABCD_0000); end
    A1 = 5'd13; #1;
    total++;
    if (Dout !== 32'h8000_0000) begin bad++; $display("FAIL cause_hold got=%h exp=%h", Dout, 32'h8000_0000); end
  endtask

  task automatic test_reset_mid_exception();
    ExcCodeIn = 5'd7; VPC = 32'h4000;
    tick();
    #1;
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL mid_exl_req got=%b exp=0", Req); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (Req !== 1'b1) begin bad++; $display("FAIL post_reset_req got=%b exp=1", Req); end
    total++;
    if (EPCOut !== 32'h0) begin bad++; $display("FAIL post_reset_epc got=%h exp=0", EPCOut); end
    A1 = 5'd12; #1;
    total++;
    if (Dout !== 32'h0) begin bad++; $display("FAIL post_reset_sr got=%h exp=0", Dout); end
    ExcCodeIn = '0; #1;
    total++;
    if (Req !== 1'b0) begin bad++; $display("FAIL post_reset_idle got=%b exp=0", Req); end
  endtask

  task automatic test_prid();
    logic [31:0] exp_prid;
`ifdef CP0_PRID_EN
    exp_prid = 32'h2023_0001;
`else
    exp_prid = 32'h0;
`endif
    WE = 1'b1; A2 = 5'd15; Din = 32'h5555_5555;
    tick();
    WE = 1'b0; A1 = 5'd15; #1;
    total++;
    if (Dout !== exp_prid) begin bad++; $display("FAIL prid got=%h exp=%h", Dout, exp_prid); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_cause_readonly();
    test_exception_vs_write();
    test_eret();
    test_write_rules();
    test_reset_mid_exception();
    test_prid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
